// File: rtl/sdram_port_arbiter_if.sv
// Request/command bundle between the VGA and USB requesters, the arbiter and the
// SDRAM controller command port.
interface sdram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 9
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [LEN_W-1:0]  vga_len;
  logic              vga_gnt;
  logic              vga_done;

  logic              usb_req;
  logic              usb_we;
  logic [ADDR_W-1:0] usb_addr;
  logic [LEN_W-1:0]  usb_len;
  logic              usb_gnt;
  logic              usb_done;

  logic              mem_req;
  logic              mem_refresh;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LEN_W-1:0]  mem_len;
  logic              mem_ack;
  logic              mem_done;

  logic [1:0]        owner;
  logic              refresh_overrun;

  // Requesters and controller side.
  modport master (
    output vga_req, vga_addr, vga_len, usb_req, usb_we, usb_addr, usb_len,
           mem_ack, mem_done,
    input  vga_gnt, vga_done, usb_gnt, usb_done, mem_req, mem_refresh, mem_we,
           mem_addr, mem_len, owner, refresh_overrun
  );

  // Arbiter side.
  modport slave (
    input  vga_req, vga_addr, vga_len, usb_req, usb_we, usb_addr, usb_len,
           mem_ack, mem_done,
    output vga_gnt, vga_done, usb_gnt, usb_done, mem_req, mem_refresh, mem_we,
           mem_addr, mem_len, owner, refresh_overrun
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Grants the single SDRAM command port to VGA, USB or auto-refresh, one burst at a
// time, and returns a done pulse to the requester that owned the burst.
module sdram_port_arbiter #(
  parameter int unsigned REFRESH_PERIOD = 390,
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned LEN_W          = 9,
  parameter int unsigned VGA_MAX_RUN    = 4
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  sdram_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int unsigned RUN_W = $clog2(VGA_MAX_RUN + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_VGA = 2'd1, OWN_USB = 2'd2, OWN_REF = 2'd3} owner_t;

  state_t            state_q;
  owner_t            owner_q, grant;
  logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [1:0]        pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              mem_req_q, refresh_q, we_q, zlen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              vga_gnt_q, usb_gnt_q, vga_done_q, usb_done_q;
  logic              wrap, zlen, finish;

  always_comb begin
    wrap = (ref_cnt_q == CNT_W'(REFRESH_PERIOD - 1));
    grant = OWN_NONE;
    if (state_q == IDLE) begin
      if (pending_q >= 2'd2)                                      grant = OWN_REF;
      else if (bus.usb_req && run_q == RUN_W'(VGA_MAX_RUN))       grant = OWN_USB;
      else if (bus.vga_req)                                       grant = OWN_VGA;
      else if (pending_q == 2'd1)                                 grant = OWN_REF;
      else if (bus.usb_req)                                       grant = OWN_USB;
    end
    zlen = (grant == OWN_VGA && bus.vga_len == '0) ||
           (grant == OWN_USB && bus.usb_len == '0);
    finish = (state_q == ISSUE && bus.mem_ack && bus.mem_done) ||
             (state_q == WAIT_DONE && (bus.mem_done || zlen_q));

    ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;
    // A wrap on the same cycle as a refresh grant cancels out.
    pending_d = pending_q;
    if (wrap && grant != OWN_REF && pending_q != 2'd3) pending_d = pending_q + 2'd1;
    else if (!wrap && grant == OWN_REF)                pending_d = pending_q - 2'd1;
    overrun_d = overrun_q | (wrap && pending_q == 2'd3);

    run_d = run_q;
    if (grant == OWN_USB) run_d = '0;
    else if (grant == OWN_VGA) begin
      if (!bus.usb_req)                          run_d = '0;
      else if (run_q != RUN_W'(VGA_MAX_RUN))     run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      ref_cnt_q  <= '0;
      pending_q  <= '0;
      overrun_q  <= 1'b0;
      run_q      <= '0;
      mem_req_q  <= 1'b0;
      refresh_q  <= 1'b0;
      we_q       <= 1'b0;
      zlen_q     <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      vga_gnt_q  <= 1'b0;
      usb_gnt_q  <= 1'b0;
      vga_done_q <= 1'b0;
      usb_done_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      run_q      <= run_d;
      vga_gnt_q  <= 1'b0;
      usb_gnt_q  <= 1'b0;
      vga_done_q <= 1'b0;
      usb_done_q <= 1'b0;
      case (state_q)
        IDLE: if (grant != OWN_NONE) begin
          owner_q <= grant;
          case (grant)
            OWN_VGA: begin
              vga_gnt_q <= 1'b1;
              refresh_q <= 1'b0;
              we_q      <= 1'b0;
              addr_q    <= bus.vga_addr;
              len_q     <= bus.vga_len;
            end
            OWN_USB: begin
              usb_gnt_q <= 1'b1;
              refresh_q <= 1'b0;
              we_q      <= bus.usb_we;
              addr_q    <= bus.usb_addr;
              len_q     <= bus.usb_len;
            end
            default: begin
              refresh_q <= 1'b1;
              we_q      <= 1'b0;
              addr_q    <= '0;
              len_q     <= '0;
            end
          endcase
          // Zero-length bursts bypass the controller and complete on the next cycle.
          zlen_q    <= zlen;
          mem_req_q <= !zlen;
          state_q   <= zlen ? WAIT_DONE : ISSUE;
        end
        ISSUE: if (bus.mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= WAIT_DONE;
        end
        WAIT_DONE: ;
        default: state_q <= IDLE;
      endcase
      if (finish) begin
        vga_done_q <= (owner_q == OWN_VGA);
        usb_done_q <= (owner_q == OWN_USB);
        owner_q    <= OWN_NONE;
        refresh_q  <= 1'b0;
        mem_req_q  <= 1'b0;
        zlen_q     <= 1'b0;
        state_q    <= IDLE;
      end
    end
  end

  assign bus.vga_gnt         = vga_gnt_q;
  assign bus.vga_done        = vga_done_q;
  assign bus.usb_gnt         = usb_gnt_q;
  assign bus.usb_done        = usb_done_q;
  assign bus.mem_req         = mem_req_q;
  assign bus.mem_refresh     = refresh_q;
  assign bus.mem_we          = we_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_len         = len_q;
  assign bus.owner           = owner_q;
  assign bus.refresh_overrun = overrun_q;
endmodule
